keccak_byte_packer: RTL and testbench

Synthesizable byte-stream front end for the `keccak` core. It accepts a message one byte at a time over a valid/ready handshake, packs the bytes into core-width words, and drives the core's `in`/`in_ready`/`is_last`/`byte_num` interface while honouring `buffer_full`. It is the parametrised, in-hardware successor to the bench-side send task: word width is generic, zero-length messages are supported, and back-pressure reaches the byte source.

---
 rtl/keccak_byte_packer.sv | 201 ++++++++++++++++++++
 tb/tb_keccak_byte_packer.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_byte_packer.sv
// Byte-stream front end for the keccak core: packs valid/ready bytes into WORD_BYTES-wide words.
// Define KECCAK_PACKER_STATS_EN to add the 16-bit completed-message counter output msg_count.
module keccak_byte_packer #(
  parameter int WORD_BYTES = 8,
  localparam int BN_W = $clog2(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  input  logic                    s_flush,
  output logic                    s_ready,
  output logic [8*WORD_BYTES-1:0] in,
  output logic                    in_ready,
  output logic                    is_last,
  output logic [BN_W-1:0]         byte_num,
  input  logic                    buffer_full
`ifdef KECCAK_PACKER_STATS_EN
  , output logic [15:0]           msg_count
`endif
);

  localparam int CNT_W = BN_W + 1;

  typedef enum logic [2:0] {
    FILL           = 3'd0,
    EMIT           = 3'd1,
    EMIT_FULL_LAST = 3'd2,
    EMIT_TERM      = 3'd3,
    EMIT_LAST      = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic                    in_ready_q, in_ready_d;
  logic                    is_last_q, is_last_d;
  logic                    s_ready_q, s_ready_d;
  logic [BN_W-1:0]         byte_num_q, byte_num_d;

  logic accept_s;
  logic flush_s;
  logic xfer_s;
  logic word_full_s;

  // A flush only counts on an idle, empty buffer; a simultaneous byte wins.
  assign accept_s    = s_ready_q & s_valid;
  assign flush_s     = s_ready_q & ~s_valid & s_flush & (cnt_q == {CNT_W{1'b0}});
  assign xfer_s      = in_ready_q & ~buffer_full;
  assign word_full_s = (cnt_q == CNT_W'(WORD_BYTES - 1));

  // Next-state and next-output computation for the pack/emit sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    in_ready_d = in_ready_q;
    is_last_d  = is_last_q;
    byte_num_d = byte_num_q;

    case (state_q)
      FILL: begin
        if (accept_s) begin
          for (int i = 0; i < WORD_BYTES; i++) begin
            word_d[8*(WORD_BYTES-1-i) +: 8] = (cnt_q == CNT_W'(i)) ? s_data
                                                                   : word_q[8*(WORD_BYTES-1-i) +: 8];
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (word_full_s && s_last) begin
            state_d    = EMIT_FULL_LAST;
            in_ready_d = 1'b1;
            is_last_d  = 1'b0;
            byte_num_d = {BN_W{1'b0}};
          end else if (word_full_s) begin
            state_d    = EMIT;
            in_ready_d = 1'b1;
            is_last_d  = 1'b0;
            byte_num_d = {BN_W{1'b0}};
          end else if (s_last) begin
            state_d    = EMIT_LAST;
            in_ready_d = 1'b1;
            is_last_d  = 1'b1;
            byte_num_d = cnt_q[BN_W-1:0] + BN_W'(1);
          end else begin
            state_d = FILL;
          end
        end else if (flush_s) begin
          state_d    = EMIT_LAST;
          in_ready_d = 1'b1;
          is_last_d  = 1'b1;
          byte_num_d = {BN_W{1'b0}};
          word_d     = {8*WORD_BYTES{1'b0}};
        end else begin
          state_d = FILL;
        end
      end

      EMIT: begin
        if (xfer_s) begin
          state_d    = FILL;
          word_d     = {8*WORD_BYTES{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
        end else begin
          state_d = EMIT;
        end
      end

      // A message that ends on a word boundary needs an empty final word.
      EMIT_FULL_LAST: begin
        if (xfer_s) begin
          state_d    = EMIT_TERM;
          word_d     = {8*WORD_BYTES{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b1;
          is_last_d  = 1'b1;
          byte_num_d = {BN_W{1'b0}};
        end else begin
          state_d = EMIT_FULL_LAST;
        end
      end

      EMIT_TERM, EMIT_LAST: begin
        if (xfer_s) begin
          state_d    = FILL;
          word_d     = {8*WORD_BYTES{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          is_last_d  = 1'b0;
          byte_num_d = {BN_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d    = FILL;
        word_d     = {8*WORD_BYTES{1'b0}};
        cnt_d      = {CNT_W{1'b0}};
        in_ready_d = 1'b0;
        is_last_d  = 1'b0;
        byte_num_d = {BN_W{1'b0}};
      end
    endcase

    s_ready_d = (state_d == FILL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      cnt_q      <= {CNT_W{1'b0}};
      word_q     <= {8*WORD_BYTES{1'b0}};
      in_ready_q <= 1'b0;
      is_last_q  <= 1'b0;
      s_ready_q  <= 1'b0;
      byte_num_q <= {BN_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      is_last_q  <= is_last_d;
      s_ready_q  <= s_ready_d;
      byte_num_q <= byte_num_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign in       = word_q;
  assign in_ready = in_ready_q;
  assign is_last  = is_last_q;
  assign byte_num = byte_num_q;

`ifdef KECCAK_PACKER_STATS_EN
  logic [15:0] msg_count_q, msg_count_d;

  // Count every final-word transfer; wraps naturally at 16 bits.
  always_comb begin
    if (xfer_s && is_last_q) begin
      msg_count_d = msg_count_q + 16'd1;
    end else begin
      msg_count_d = msg_count_q;
    end
  end

  // Message counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_count_q <= 16'd0;
    end else begin
      msg_count_q <= msg_count_d;
    end
  end

  assign msg_count = msg_count_q;
`endif

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Self-checking bench for keccak_byte_packer: random byte streams compared with a word-chunking model.
module tb_keccak_byte_packer;
  localparam int WB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_flush, s_ready;
  logic [63:0] in_w;
  logic        in_ready, is_last, buffer_full;
  logic [2:0]  byte_num;

  logic [7:0]  s4_data;
  logic        s4_valid, s4_last, s4_flush, s4_ready;
  logic [31:0] in4;
  logic        in4_ready, is_last4, bf4;
  logic [1:0]  byte_num4;
`ifdef KECCAK_PACKER_STATS_EN
  logic [15:0] msg_count8, msg_count4;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  msg_q[$];
  logic [63:0] exp_data[$], obs_data[$];
  bit          exp_last[$], obs_last[$];
  logic [2:0]  exp_bn[$], obs_bn[$];
  int          obs_cyc[$];
  logic [31:0] obs4_data[$];
  bit          obs4_last[$];
  logic [1:0]  obs4_bn[$];

  keccak_byte_packer #(.WORD_BYTES(8)) u_dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_flush(s_flush), .s_ready(s_ready), .in(in_w), .in_ready(in_ready),
    .is_last(is_last), .byte_num(byte_num), .buffer_full(buffer_full)
`ifdef KECCAK_PACKER_STATS_EN
    , .msg_count(msg_count8)
`endif
  );

  keccak_byte_packer #(.WORD_BYTES(4)) u_dut4 (
    .clk(clk), .reset(reset), .s_data(s4_data), .s_valid(s4_valid), .s_last(s4_last),
    .s_flush(s4_flush), .s_ready(s4_ready), .in(in4), .in_ready(in4_ready),
    .is_last(is_last4), .byte_num(byte_num4), .buffer_full(bf4)
`ifdef KECCAK_PACKER_STATS_EN
    , .msg_count(msg_count4)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every word handed to the core.
  always @(negedge clk) begin
    if (reset && in_ready && !buffer_full) begin
      obs_data.push_back(in_w); obs_last.push_back(is_last); obs_bn.push_back(byte_num);
      obs_cyc.push_back(cyc);
    end
    if (reset && in4_ready && !bf4) begin
      obs4_data.push_back(in4); obs4_last.push_back(is_last4); obs4_bn.push_back(byte_num4);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    msg_q.delete(); exp_data.delete(); exp_last.delete(); exp_bn.delete();
    obs_data.delete(); obs_last.delete(); obs_bn.delete(); obs_cyc.delete();
  endtask

  // Reference: cut msg_q[from..from+len-1] into WB-byte words, zero-padded, plus terminator if aligned.
  task automatic model_msg(input int from, input int len);
    int nw;
    nw = (len + WB - 1) / WB;
    for (int w = 0; w < nw; w++) begin
      logic [63:0] d;
      int nb;
      d = 64'd0; nb = 0;
      for (int b = 0; b < WB; b++) begin
        if (w*WB + b < len) begin
          d[8*(WB-1-b) +: 8] = msg_q[from + w*WB + b];
          nb++;
        end
      end
      exp_data.push_back(d); exp_last.push_back(nb < WB); exp_bn.push_back(3'(nb % WB));
    end
    if (len % WB == 0) begin
      exp_data.push_back(64'd0); exp_last.push_back(1'b1); exp_bn.push_back(3'd0);
    end
  endtask

  task automatic do_flush();
    int g;
    g = 0;
    while (!s_ready && g < 500) begin @(posedge clk); #1; g++; end
    s_flush = 1'b1;
    @(posedge clk); #1;
    s_flush = 1'b0;
  endtask

  task automatic send_msg(input int from, input int len, input bit last_en, input bit gaps);
    if (len == 0) begin
      do_flush();
    end else begin
      for (int i = 0; i < len; i++) begin
        int g;
        bit acc;
        if (gaps && $urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        s_valid = 1'b1; s_data = msg_q[from + i]; s_last = last_en && (i == len - 1);
        g = 0;
        forever begin
          @(negedge clk); acc = s_ready;
          @(posedge clk); #1;
          if (acc) break;
          g++;
          if (g > 500) begin
            checks++; errors++;
            $display("FAIL send_stall: byte %0d not accepted, got s_ready=%b required 1", i, s_ready);
            break;
          end
        end
      end
      s_valid = 1'b0; s_last = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int g;
    g = 0;
    while (obs_data.size() < exp_data.size() && g < budget) begin @(negedge clk); g++; end
    repeat (WB + 4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, in_ready, is_last} !== 3'b000 || in_w !== 64'd0 || byte_num !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got s_ready=%b in_ready=%b is_last=%b in=%h byte_num=%0d required all 0",
               s_ready, in_ready, is_last, in_w, byte_num);
    end
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b required 0", s_ready); end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_byte();
    clear_q();
    msg_q.push_back(8'h31);
    model_msg(0, 1);
    send_msg(0, 1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_w !== 64'h3100000000000000 || is_last !== 1'b1 ||
        byte_num !== 3'd1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_byte: got rdy=%b in=%h last=%b bn=%0d s_ready=%b required 1/3100000000000000/1/1/0",
               in_ready, in_w, is_last, byte_num, s_ready);
    end
    wait_drain(200);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL single_count: got %0d words required %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_bn[i] !== exp_bn[i]) begin
        errors++;
        $display("FAIL single_word[%0d]: got %h/%b/%0d required %h/%b/%0d", i, obs_data[i], obs_last[i],
                 obs_bn[i], exp_data[i], exp_last[i], exp_bn[i]);
      end
    end
  endtask

  task automatic test_full_word_term();
    clear_q();
    for (int i = 1; i <= 8; i++) msg_q.push_back(8'(i));
    model_msg(0, 8);
    send_msg(0, 8, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_w !== 64'h0102030405060708 || is_last !== 1'b0) begin
      errors++;
      $display("FAIL full_word: got rdy=%b in=%h last=%b required 1/0102030405060708/0", in_ready, in_w, is_last);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_w !== 64'd0 || is_last !== 1'b1 || byte_num !== 3'd0) begin
      errors++;
      $display("FAIL terminator: got rdy=%b in=%h last=%b bn=%0d required 1/0/1/0", in_ready, in_w, is_last, byte_num);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_term: got in_ready=%b s_ready=%b required 0/1", in_ready, s_ready);
    end
    wait_drain(200);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL term_count: got %0d words required %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_bn[i] !== exp_bn[i]) begin
        errors++;
        $display("FAIL term_word[%0d]: got %h/%b/%0d required %h/%b/%0d", i, obs_data[i], obs_last[i],
                 obs_bn[i], exp_data[i], exp_last[i], exp_bn[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int i = 0; i < 16; i++) msg_q.push_back(8'($urandom));
    model_msg(0, 16);
    send_msg(0, 16, 1'b1, 1'b0);
    wait_drain(200);
    checks++;
    if (obs_cyc.size() < 3) begin
      errors++; $display("FAIL b2b_count: got %0d words required 3", obs_cyc.size());
    end else if (obs_cyc[1] - obs_cyc[0] != WB + 1 || obs_cyc[2] - obs_cyc[1] != 1) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d,%0d cycles required %0d,1", obs_cyc[1] - obs_cyc[0],
               obs_cyc[2] - obs_cyc[1], WB + 1);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_bn[i] !== exp_bn[i]) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got %h/%b/%0d required %h/%b/%0d", i, obs_data[i], obs_last[i],
                 obs_bn[i], exp_data[i], exp_last[i], exp_bn[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    for (int i = 0; i < 40; i++) msg_q.push_back(8'($urandom));
    model_msg(0, 40);
    fork
      send_msg(0, 40, 1'b1, 1'b0);
      begin
        int g;
        logic [63:0] held;
        g = 0;
        while (obs_data.size() < 2 && g < 500) begin @(posedge clk); #1; g++; end
        buffer_full = 1'b1;
        g = 0;
        do begin @(negedge clk); g++; end while (!in_ready && g < 500);
        held = in_w;
        repeat (10) begin
          checks++;
          if (in_w !== held || in_ready !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got in=%h rdy=%b s_ready=%b required %h/1/0", in_w, in_ready, s_ready, held);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        buffer_full = 1'b0;
      end
    join
    wait_drain(500);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL bp_count: got %0d words required %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_bn[i] !== exp_bn[i]) begin
        errors++;
        $display("FAIL bp_word[%0d]: got %h/%b/%0d required %h/%b/%0d", i, obs_data[i], obs_last[i],
                 obs_bn[i], exp_data[i], exp_last[i], exp_bn[i]);
      end
    end
  endtask

  task automatic test_flush();
    clear_q();
    model_msg(0, 0);
    do_flush();
    for (int i = 0; i < 5; i++) msg_q.push_back(8'($urandom));
    model_msg(0, 5);
    send_msg(0, 3, 1'b0, 1'b0);
    do_flush();
    s_flush = 1'b1;
    send_msg(3, 2, 1'b1, 1'b0);
    s_flush = 1'b0;
    wait_drain(300);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL flush_count: got %0d words required %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_bn[i] !== exp_bn[i]) begin
        errors++;
        $display("FAIL flush_word[%0d]: got %h/%b/%0d required %h/%b/%0d", i, obs_data[i], obs_last[i],
                 obs_bn[i], exp_data[i], exp_last[i], exp_bn[i]);
      end
    end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    clear_q();
    fork
      begin
        for (int m = 0; m < 12; m++) begin
          int len, from;
          len = $urandom_range(0, 20);
          from = msg_q.size();
          for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
          model_msg(from, len);
          send_msg(from, len, 1'b1, 1'b1);
        end
        wait_drain(3000);
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; buffer_full = ($urandom_range(0, 2) == 0); end
        buffer_full = 1'b0;
      end
    join
    wait_drain(200);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL rand_count: got %0d words required %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_bn[i] !== exp_bn[i]) begin
        errors++;
        $display("FAIL rand_word[%0d]: got %h/%b/%0d required %h/%b/%0d", i, obs_data[i], obs_last[i],
                 obs_bn[i], exp_data[i], exp_last[i], exp_bn[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    for (int i = 0; i < 3; i++) msg_q.push_back(8'($urandom));
    send_msg(0, 3, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, in_ready, is_last} !== 3'b000 || in_w !== 64'd0 || byte_num !== 3'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got s_ready=%b in_ready=%b is_last=%b in=%h bn=%0d required all 0",
               s_ready, in_ready, is_last, in_w, byte_num);
    end
    @(posedge clk); #1; reset = 1'b1;
    clear_q();
    msg_q.push_back(8'hAA);
    model_msg(0, 1);
    send_msg(0, 1, 1'b1, 1'b0);
    wait_drain(200);
    checks++;
    if (obs_data.size() != 1 || exp_data[0] !== 64'hAA00000000000000) begin
      errors++; $display("FAIL midreset_count: got %0d words required 1", obs_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_bn[i] !== exp_bn[i]) begin
        errors++;
        $display("FAIL midreset_word[%0d]: got %h/%b/%0d required %h/%b/%0d", i, obs_data[i], obs_last[i],
                 obs_bn[i], exp_data[i], exp_last[i], exp_bn[i]);
      end
    end
  endtask

  task automatic test_wb4();
    obs4_data.delete(); obs4_last.delete(); obs4_bn.delete();
    for (int i = 0; i < 6; i++) begin
      int g;
      bit acc;
      s4_valid = 1'b1; s4_data = 8'h11 + 8'(i); s4_last = (i == 5);
      g = 0;
      forever begin
        @(negedge clk); acc = s4_ready;
        @(posedge clk); #1;
        if (acc) break;
        g++;
        if (g > 100) begin
          checks++; errors++;
          $display("FAIL wb4_stall: got s_ready=%b required 1", s4_ready);
          break;
        end
      end
    end
    s4_valid = 1'b0; s4_last = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (obs4_data.size() != 2) begin
      errors++; $display("FAIL wb4_count: got %0d words required 2", obs4_data.size());
    end else begin
      checks++;
      if (obs4_data[0] !== 32'h11121314 || obs4_last[0] !== 1'b0) begin
        errors++; $display("FAIL wb4_word0: got %h/%b required 11121314/0", obs4_data[0], obs4_last[0]);
      end
      checks++;
      if (obs4_data[1] !== 32'h15160000 || obs4_last[1] !== 1'b1 || obs4_bn[1] !== 2'd2) begin
        errors++;
        $display("FAIL wb4_word1: got %h/%b/%0d required 15160000/1/2", obs4_data[1], obs4_last[1], obs4_bn[1]);
      end
    end
`ifdef KECCAK_PACKER_STATS_EN
    checks++;
    if (msg_count4 !== 16'd1) begin errors++; $display("FAIL wb4_msg_count: got %0d required 1", msg_count4); end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0; s_flush = 1'b0; buffer_full = 1'b0;
    s4_data = 8'd0; s4_valid = 1'b0; s4_last = 1'b0; s4_flush = 1'b0; bf4 = 1'b0;
    test_reset();
    test_single_byte();
    test_full_word_term();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    test_wb4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
